// File: rtl/iq_pkg.sv
// Shared constants and the default-width entry layout for the instruction queue.
package iq_pkg;

  localparam int IQ_OP_W  = 5;
  localparam int IQ_REG_W = 5;
  localparam int IQ_IMM_W = 32;

  typedef struct packed {
    logic [IQ_OP_W-1:0]  op;
    logic [IQ_REG_W-1:0] rs1;
    logic [IQ_REG_W-1:0] rs2;
    logic [IQ_REG_W-1:0] rd;
    logic [IQ_IMM_W-1:0] imm;
    logic                has_imm;
  } iq_entry_t;

  localparam int IQ_ENTRY_W = $bits(iq_entry_t);
  localparam logic [IQ_OP_W-1:0] NOP_OP = {IQ_OP_W{1'b1}};

endpackage

// File: rtl/iq_entry_ram.sv
// Entry storage for instr_queue: one synchronous write port, one asynchronous read port.
module iq_entry_ram
  import iq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = IQ_ENTRY_W
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [W-1:0]               wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [W-1:0]               rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_queue.sv
// Decoded-instruction FIFO with first-word-fall-through output and flush.
// Optional stall counter output enabled by macro INSTR_QUEUE_STALL_CNT_EN.
module instr_queue
  import iq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int OP_W     = IQ_OP_W,
  parameter int REG_W    = IQ_REG_W,
  parameter int IMM_W    = IQ_IMM_W,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          in_op,
  input  logic [REG_W-1:0]         in_rs1,
  input  logic [REG_W-1:0]         in_rs2,
  input  logic [REG_W-1:0]         in_rd,
  input  logic [IMM_W-1:0]         in_imm,
  input  logic                     in_has_imm,
  input  logic                     rs_full,
  input  logic                     rob_full,
  output logic                     out_valid,
  output logic [OP_W-1:0]          out_op,
  output logic [REG_W-1:0]         out_rs1,
  output logic [REG_W-1:0]         out_rs2,
  output logic [REG_W-1:0]         out_rd,
  output logic [IMM_W-1:0]         out_imm,
  output logic                     out_has_imm,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
`ifdef INSTR_QUEUE_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = OP_W + 3 * REG_W + IMM_W + 1;
  localparam logic [AW:0] ONE_P = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

  logic [AW:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          almost_full_q, almost_full_d;
  logic          empty_s, full_s, enq_s, deq_s;
  logic [EW-1:0] wdata_s, rdata_s;

  // Indices equal: empty if wrap bits match, full if they differ.
  assign empty_s = (head_q == tail_q);
  assign full_s  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);
  assign enq_s   = in_valid && !full_s;
  assign deq_s   = !empty_s && !rs_full && !rob_full;

  // Next-state pointers, occupancy and almost-full; flush clears everything.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = {(AW+1){1'b0}};
      tail_d  = {(AW+1){1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (enq_s) begin
        tail_d = tail_q + ONE_P;
      end else begin
        tail_d = tail_q;
      end
      if (deq_s) begin
        head_d = head_q + ONE_P;
      end else begin
        head_d = head_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + ONE_P;
        2'b01:   count_d = count_q - ONE_P;
        default: count_d = count_q;
      endcase
    end
    almost_full_d = (count_d >= AFULL_C);
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q        <= {(AW+1){1'b0}};
      tail_q        <= {(AW+1){1'b0}};
      count_q       <= {CW{1'b0}};
      almost_full_q <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign wdata_s = {in_op, in_rs1, in_rs2, in_rd, in_imm, in_has_imm};

  iq_entry_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_ram (
    .clk   (clk),
    .we    (rst && !flush && enq_s),
    .waddr (tail_q[AW-1:0]),
    .wdata (wdata_s),
    .raddr (head_q[AW-1:0]),
    .rdata (rdata_s)
  );

  // Head presentation; an empty queue shows a NOP with zeroed fields.
  always_comb begin
    if (!empty_s) begin
      {out_op, out_rs1, out_rs2, out_rd, out_imm, out_has_imm} = rdata_s;
    end else begin
      out_op      = {OP_W{1'b1}};
      out_rs1     = {REG_W{1'b0}};
      out_rs2     = {REG_W{1'b0}};
      out_rd      = {REG_W{1'b0}};
      out_imm     = {IMM_W{1'b0}};
      out_has_imm = 1'b0;
    end
  end

  assign out_valid   = !empty_s;
  assign in_ready    = !full_s;
  assign count       = count_q;
  assign almost_full = almost_full_q;

`ifdef INSTR_QUEUE_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles where the head is held by back-pressure.
  always_comb begin
    stall_d = stall_q;
    if (flush) begin
      stall_d = 32'd0;
    end else if (!empty_s && (rs_full || rob_full) && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_instr_queue;
  import iq_pkg::*;

  localparam int DEPTH = 16;
  localparam int AFULL = DEPTH - 2;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [4:0]  in_op, in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        in_has_imm, rs_full, rob_full;
  logic        out_valid;
  logic [4:0]  out_op, out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic        out_has_imm, almost_full;
  logic [4:0]  count;
`ifdef INSTR_QUEUE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_imm(in_imm), .in_has_imm(in_has_imm), .rs_full(rs_full), .rob_full(rob_full),
    .out_valid(out_valid), .out_op(out_op), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_imm(out_imm), .out_has_imm(out_has_imm),
    .count(count), .almost_full(almost_full)
`ifdef INSTR_QUEUE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  iq_entry_t   mq[$];
  logic [31:0] stall_m = 32'd0;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    iq_entry_t e;
    if (mq.size() > 0) begin
      e = mq[0];
    end else begin
      e = '{op: NOP_OP, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 32'd0, has_imm: 1'b0};
    end
    chk("out_valid",   64'(out_valid),   64'(mq.size() > 0));
    chk("out_op",      64'(out_op),      64'(e.op));
    chk("out_rs1",     64'(out_rs1),     64'(e.rs1));
    chk("out_rs2",     64'(out_rs2),     64'(e.rs2));
    chk("out_rd",      64'(out_rd),      64'(e.rd));
    chk("out_imm",     64'(out_imm),     64'(e.imm));
    chk("out_has_imm", 64'(out_has_imm), 64'(e.has_imm));
    chk("count",       64'(count),       64'(mq.size()));
    chk("almost_full", 64'(almost_full), 64'(mq.size() >= AFULL));
    chk("in_ready",    64'(in_ready),    64'(mq.size() < DEPTH));
`ifdef INSTR_QUEUE_STALL_CNT_EN
    chk("stall_cnt",   64'(stall_cnt),   64'(stall_m));
`endif
  endtask

  // One clock: model follows the queue rules using inputs held across the edge.
  task automatic cycle();
    bit enq, deq, stall;
    iq_entry_t e;
    enq   = in_valid && (mq.size() < DEPTH);
    deq   = (mq.size() > 0) && !rs_full && !rob_full;
    stall = (mq.size() > 0) && (rs_full || rob_full);
    e = '{op: in_op, rs1: in_rs1, rs2: in_rs2, rd: in_rd, imm: in_imm, has_imm: in_has_imm};
    @(posedge clk);
    if (!rst || flush) begin
      mq.delete();
      stall_m = 32'd0;
    end else begin
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back(e);
      if (stall && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 32'd1;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_fields();
    in_op      = 5'($urandom_range(0, 30));
    in_rs1     = 5'($urandom);
    in_rs2     = 5'($urandom);
    in_rd      = 5'($urandom);
    in_imm     = $urandom;
    in_has_imm = 1'($urandom);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; rs_full = 1'b0; rob_full = 1'b0;
    rand_fields();
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_out_op", 64'(out_op), 64'h1F);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b1;
    cycle();

    // First enqueue is visible on the next cycle.
    in_valid = 1'b1; in_op = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd0; in_rd = 5'd2;
    in_imm = 32'h10; in_has_imm = 1'b1; rs_full = 1'b1;
    cycle();
    chk("first_op", 64'(out_op), 64'd3);
    chk("first_count", 64'(count), 64'd1);
    in_valid = 1'b0; rs_full = 1'b0;
    cycle();

    // Fill under back-pressure, then offer one more.
    rs_full = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      rand_fields();
      cycle();
    end
    chk("full_ready", 64'(in_ready), 64'd0);
    rand_fields();
    cycle();
    chk("full_count", 64'(count), 64'd16);

    // Releasing back-pressure while full: dequeue only on the first cycle.
    rs_full = 1'b0;
    cycle();
    chk("drain_count", 64'(count), 64'd15);
    chk("drain_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) cycle();

    // Steady one-in one-out across pointer wrap.
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_fields();
      cycle();
      chk("steady_count", 64'(count), 64'd1);
    end
    in_valid = 1'b0;
    cycle();

    // Flush overrides a concurrent enqueue.
    rs_full = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      cycle();
    end
    flush = 1'b1;
    rand_fields();
    cycle();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_op", 64'(out_op), 64'h1F);
    flush = 1'b0; in_valid = 1'b0; rs_full = 1'b0;
    cycle();

`ifdef INSTR_QUEUE_STALL_CNT_EN
    in_valid = 1'b1; rand_fields();
    cycle();
    in_valid = 1'b0; rob_full = 1'b1;
    for (int i = 0; i < 7; i++) cycle();
    chk("stall7", 64'(stall_cnt), 64'd7);
    rob_full = 1'b0; flush = 1'b1;
    cycle();
    chk("stall_flush", 64'(stall_cnt), 64'd0);
    flush = 1'b0;
    cycle();
`endif

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      rand_fields();
      in_valid = ($urandom_range(0, 99) < 60);
      rs_full  = ($urandom_range(0, 99) < 30);
      rob_full = ($urandom_range(0, 99) < 15);
      flush    = ($urandom_range(0, 199) == 0);
      rst      = !($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 1'b1; flush = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
